uart_pixel_writer: RTL and testbench

Receive-side pixel assembler between the UART byte receiver and the 24-bit frame buffer. Packs a stream of 8-bit UART bytes, three per pixel in R, G, B order, into 24-bit words. Writes each word to the frame buffer write port at sequential raster addresses. Signals completion once a full frame has been stored, which the downstream processing stage uses as its start condition.

---
 rtl/frame_pkg.sv | 19 +
 rtl/uart_pixel_writer.sv | 148 ++++++++++++++
 tb/tb_uart_pixel_writer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/frame_pkg.sv
// Frame geometry defaults and receive-FSM state type, shared by the pixel writer,
// the frame buffer and the processing stage.
package frame_pkg;

  localparam int IMG_WIDTH  = 1280;
  localparam int IMG_HEIGHT = 720;
  localparam int PIXEL_BITS = 24;
  localparam int MEM_DEPTH  = IMG_WIDTH * IMG_HEIGHT;
  localparam int ADDR_WIDTH = $clog2(MEM_DEPTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GET_R = 3'd1,
    GET_G = 3'd2,
    GET_B = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/uart_pixel_writer.sv
// Packs UART bytes (R,G,B order) into 24-bit pixels written at raster addresses.
// Optional inter-byte timeout: define UART_PIXEL_WRITER_TIMEOUT_EN.
module uart_pixel_writer #(
  parameter int IMG_WIDTH  = frame_pkg::IMG_WIDTH,
  parameter int IMG_HEIGHT = frame_pkg::IMG_HEIGHT,
  parameter int PIXEL_BITS = frame_pkg::PIXEL_BITS,
`ifdef UART_PIXEL_WRITER_TIMEOUT_EN
  parameter int TIMEOUT_CYCLES = 1_000_000,
`endif
  localparam int MEM_DEPTH  = IMG_WIDTH * IMG_HEIGHT,
  localparam int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [PIXEL_BITS-1:0] wr_data,
  output logic                  wr_en,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  sync_err
);

  import frame_pkg::state_t;
  import frame_pkg::IDLE;
  import frame_pkg::GET_R;
  import frame_pkg::GET_G;
  import frame_pkg::GET_B;
  import frame_pkg::DONE;

  state_t                state_r;
  state_t                next_state_s;
  logic [7:0]            r_r;
  logic [7:0]            g_r;
  logic [ADDR_WIDTH-1:0] addr_cnt_r;
  logic [ADDR_WIDTH-1:0] wr_addr_r;
  logic [PIXEL_BITS-1:0] wr_data_r;
  logic                  wr_en_r;
  logic                  busy_r;
  logic                  frame_done_r;
  logic                  sync_err_r;
  logic                  last_pix_s;
  logic                  timeout_s;

  assign last_pix_s = (addr_cnt_r == ADDR_WIDTH'(MEM_DEPTH - 1));

`ifdef UART_PIXEL_WRITER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt_r;

  // Counts idle cycles mid-pixel only; GET_R and any accepted byte clear it.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt_r <= TMO_W'(0);
    end else if ((state_r == GET_G || state_r == GET_B) && !rx_valid && !timeout_s) begin
      tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
    end else begin
      tmo_cnt_r <= TMO_W'(0);
    end
  end

  assign timeout_s = (state_r == GET_G || state_r == GET_B) && !rx_valid &&
                     (tmo_cnt_r == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_s = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) next_state_s = GET_R;
        else       next_state_s = IDLE;
      end
      GET_R: begin
        if (rx_valid) next_state_s = GET_G;
        else          next_state_s = GET_R;
      end
      GET_G: begin
        if (rx_valid)       next_state_s = GET_B;
        else if (timeout_s) next_state_s = GET_R;
        else                next_state_s = GET_G;
      end
      GET_B: begin
        if (rx_valid)       next_state_s = last_pix_s ? DONE : GET_R;
        else if (timeout_s) next_state_s = GET_R;
        else                next_state_s = GET_B;
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // busy also covers DONE so it stays high through the final write cycle
  // and drops together with the frame_done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_r          <= 8'h00;
      g_r          <= 8'h00;
      addr_cnt_r   <= ADDR_WIDTH'(0);
      wr_addr_r    <= ADDR_WIDTH'(0);
      wr_data_r    <= PIXEL_BITS'(0);
      wr_en_r      <= 1'b0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
      sync_err_r   <= 1'b0;
    end else begin
      wr_en_r      <= (state_r == GET_B) && rx_valid;
      busy_r       <= (next_state_s != IDLE);
      frame_done_r <= (state_r == DONE);
      sync_err_r   <= timeout_s;
      if (state_r == IDLE && start) begin
        addr_cnt_r <= ADDR_WIDTH'(0);
      end
      if (state_r == GET_R && rx_valid) begin
        r_r <= rx_data;
      end
      if (state_r == GET_G && rx_valid) begin
        g_r <= rx_data;
      end
      if (state_r == GET_B && rx_valid) begin
        wr_data_r <= {r_r, g_r, rx_data};
        wr_addr_r <= addr_cnt_r;
        if (!last_pix_s) begin
          addr_cnt_r <= addr_cnt_r + ADDR_WIDTH'(1);
        end
      end
    end
  end

  assign wr_addr    = wr_addr_r;
  assign wr_data    = wr_data_r;
  assign wr_en      = wr_en_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;
  assign sync_err   = sync_err_r;

endmodule

// File: tb/tb_uart_pixel_writer.sv
// Directed bench: table of per-cycle vectors on a 4x2 frame, plus hand-written
// timeout and default-geometry (forced address counter) sequences.
module tb_uart_pixel_writer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic [2:0]  wr_addr;
  logic [23:0] wr_data;
  logic        wr_en, busy, frame_done, sync_err;

  logic        start_b = 1'b0;
  logic        rx_valid_b = 1'b0;
  logic [7:0]  rx_data_b = 8'h00;
  logic [19:0] wr_addr_b;
  logic [23:0] wr_data_b;
  logic        wr_en_b, busy_b, frame_done_b, sync_err_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  uart_pixel_writer #(
    .IMG_WIDTH(4),
    .IMG_HEIGHT(2)
`ifdef UART_PIXEL_WRITER_TIMEOUT_EN
    , .TIMEOUT_CYCLES(10)
`endif
  ) dut (
    .clk(clk), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en), .busy(busy),
    .frame_done(frame_done), .sync_err(sync_err)
  );

  uart_pixel_writer dut_big (
    .clk(clk), .reset(reset), .start(start_b), .rx_data(rx_data_b), .rx_valid(rx_valid_b),
    .wr_addr(wr_addr_b), .wr_data(wr_data_b), .wr_en(wr_en_b), .busy(busy_b),
    .frame_done(frame_done_b), .sync_err(sync_err_b)
  );

  typedef struct {
    logic        rst;
    logic        st;
    logic        rv;
    logic [7:0]  d;
    logic        we;
    logic [2:0]  a;
    logic [23:0] wd;
    logic        bz;
    logic        dn;
    logic        chk;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rst, input logic st, input logic rv,
                              input logic [7:0] d, input logic we, input logic [2:0] a,
                              input logic [23:0] wd, input logic bz, input logic dn,
                              input logic chk);
    vec_t v;
    v.rst = rst; v.st = st; v.rv = rv; v.d = d; v.we = we; v.a = a;
    v.wd = wd; v.bz = bz; v.dn = dn; v.chk = chk;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic st, input logic rv, input logic [7:0] d);
    start = st; rx_valid = rv; rx_data = d;
    @(posedge clk); #1;
  endtask

  task automatic step_b(input logic st, input logic rv, input logic [7:0] d);
    start_b = st; rx_valid_b = rv; rx_data_b = d;
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset, then IDLE bytes (incl. one coinciding with start) must be dropped.
    add(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 24'h0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 8'h99, 1'b0, 3'd0, 24'h0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b1, 8'h77, 1'b0, 3'd0, 24'h0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 3'd0, 24'h0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 8'h22, 1'b0, 3'd0, 24'h0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 8'h33, 1'b1, 3'd0, 24'h112233, 1'b1, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 24'h0, 1'b1, 1'b0, 1'b0);
    // Mid-frame starts must not disturb address or state.
    add(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 24'h0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 8'h44, 1'b0, 3'd0, 24'h0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 3'd0, 24'h0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 8'h66, 1'b1, 3'd1, 24'h445566, 1'b1, 1'b0, 1'b1);
    for (int k = 2; k < 8; k++) begin
      logic [7:0] rr, gg, bb;
      rr = 8'(16 * k + 1); gg = 8'(16 * k + 2); bb = 8'(16 * k + 3);
      add(1'b0, 1'b0, 1'b1, rr, 1'b0, 3'd0, 24'h0, 1'b1, 1'b0, 1'b0);
      add(1'b0, 1'b0, 1'b1, gg, 1'b0, 3'd0, 24'h0, 1'b1, 1'b0, 1'b0);
      add(1'b0, 1'b0, 1'b1, bb, 1'b1, 3'(k), {rr, gg, bb}, 1'b1, 1'b0, 1'b1);
    end
    add(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 24'h0, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 24'h0, 1'b0, 1'b0, 1'b0);
    // Full frame, 24 bytes back-to-back.
    add(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 24'h0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 24; i++) begin
      if (i % 3 == 2)
        add(1'b0, 1'b0, 1'b1, 8'(i + 1), 1'b1, 3'(i / 3),
            {8'(i - 1), 8'(i), 8'(i + 1)}, 1'b1, 1'b0, 1'b1);
      else
        add(1'b0, 1'b0, 1'b1, 8'(i + 1), 1'b0, 3'd0, 24'h0, 1'b1, 1'b0, 1'b0);
    end
    add(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 24'h0, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 24'h0, 1'b0, 1'b0, 1'b0);
    // Reset mid-pixel discards the partial pixel and clears the outputs.
    add(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 24'h0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 8'hAA, 1'b0, 3'd0, 24'h0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 8'hBB, 1'b0, 3'd0, 24'h0, 1'b1, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 24'h0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 24'h0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 8'h01, 1'b0, 3'd0, 24'h0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 8'h02, 1'b0, 3'd0, 24'h0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 8'h03, 1'b1, 3'd0, 24'h010203, 1'b1, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 24'h0, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst; start = vecs[i].st;
      rx_valid = vecs[i].rv; rx_data = vecs[i].d;
      @(posedge clk); #1;
      check($sformatf("row%0d wr_en", i), 32'(wr_en), 32'(vecs[i].we));
      check($sformatf("row%0d busy", i), 32'(busy), 32'(vecs[i].bz));
      check($sformatf("row%0d frame_done", i), 32'(frame_done), 32'(vecs[i].dn));
      check($sformatf("row%0d sync_err", i), 32'(sync_err), 32'd0);
      if (vecs[i].chk) begin
        check($sformatf("row%0d wr_addr", i), 32'(wr_addr), 32'(vecs[i].a));
        check($sformatf("row%0d wr_data", i), 32'(wr_data), 32'(vecs[i].wd));
      end
    end
    reset = 1'b0; start = 1'b0; rx_valid = 1'b0;

    // Stalled partial pixel: fresh reset, start, one byte, then silence.
    reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h55);
`ifdef UART_PIXEL_WRITER_TIMEOUT_EN
    for (int c = 1; c <= 10; c++) begin
      step(1'b0, 1'b0, 8'h00);
      check($sformatf("tmo c%0d sync_err", c), 32'(sync_err), (c == 10) ? 32'd1 : 32'd0);
      check($sformatf("tmo c%0d wr_en", c), 32'(wr_en), 32'd0);
    end
    step(1'b0, 1'b0, 8'h00);
    check("tmo pulse width", 32'(sync_err), 32'd0);
    check("tmo busy", 32'(busy), 32'd1);
    step(1'b0, 1'b1, 8'h01);
    step(1'b0, 1'b1, 8'h02);
    step(1'b0, 1'b1, 8'h03);
    check("tmo resync wr_en", 32'(wr_en), 32'd1);
    check("tmo resync wr_addr", 32'(wr_addr), 32'd0);
    check("tmo resync wr_data", 32'(wr_data), 32'h010203);
`else
    for (int c = 1; c <= 30; c++) begin
      step(1'b0, 1'b0, 8'h00);
      if (sync_err !== 1'b0 || wr_en !== 1'b0)
        check($sformatf("wait c%0d sync_err|wr_en", c), 32'({sync_err, wr_en}), 32'd0);
    end
    check("wait busy", 32'(busy), 32'd1);
    step(1'b0, 1'b1, 8'h66);
    step(1'b0, 1'b1, 8'h77);
    check("wait resume wr_en", 32'(wr_en), 32'd1);
    check("wait resume wr_addr", 32'(wr_addr), 32'd0);
    check("wait resume wr_data", 32'(wr_data), 32'h556677);
    check("wait sync_err", 32'(sync_err), 32'd0);
`endif

    // Default geometry: jump the counter near the end of a 1280x720 frame.
    step_b(1'b1, 1'b0, 8'h00);
    check("big busy", 32'(busy_b), 32'd1);
    force dut_big.addr_cnt_r = 20'd921598;
    @(posedge clk); #1;
    release dut_big.addr_cnt_r;
    for (int j = 0; j < 6; j++) begin
      step_b(1'b0, 1'b1, 8'(j + 1));
      if (j == 2) begin
        check("big w0 wr_en", 32'(wr_en_b), 32'd1);
        check("big w0 wr_addr", 32'(wr_addr_b), 32'd921598);
        check("big w0 wr_data", 32'(wr_data_b), 32'h010203);
      end else if (j == 5) begin
        check("big w1 wr_en", 32'(wr_en_b), 32'd1);
        check("big w1 wr_addr", 32'(wr_addr_b), 32'd921599);
        check("big w1 wr_data", 32'(wr_data_b), 32'h040506);
        check("big w1 busy", 32'(busy_b), 32'd1);
      end else begin
        check($sformatf("big b%0d wr_en", j), 32'(wr_en_b), 32'd0);
      end
      check($sformatf("big b%0d frame_done", j), 32'(frame_done_b), 32'd0);
    end
    step_b(1'b0, 1'b0, 8'h00);
    check("big frame_done", 32'(frame_done_b), 32'd1);
    check("big busy after", 32'(busy_b), 32'd0);
    check("big wr_en after", 32'(wr_en_b), 32'd0);
    step_b(1'b0, 1'b0, 8'h00);
    check("big frame_done width", 32'(frame_done_b), 32'd0);
    check("big sync_err", 32'(sync_err_b), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
